auth_req_rx: RTL and testbench
==============================

AUTH_REQ_RX -- requirements
Module: auth_req_rx

Interface
REQ-001 SHALL declare parameter: TIMEOUT_CYCLES, 16'd1000, req/err ack watchdog limit in clk cycles (used only when AUTH_RX_TIMEOUT_EN defined).
REQ-002 SHALL declare port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL declare port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL declare port: msg_valid  input  1  driver presents an authentication message.
REQ-005 SHALL declare port: msg_in  input  `MSG_LEN  message; [MSG_LEN-1-:8] version, next 8 type, param1, param2, then 16-bit offset, then 16-bit length.
REQ-006 SHALL declare port: msg_src  input  1  0=PD path, 1=DEBUG path.
REQ-007 SHALL declare port: slot_mask  input  8  bit n=1 means certificate slot n provisioned.
REQ-008 SHALL declare port: msg_ready  output  1  block can accept a message.
REQ-009 SHALL declare ports: req_valid output 1; req_type output 8; req_slot output 3; req_offset output 16; req_length output 16; req_src output 1 -- decoded request to responder core.
REQ-010 SHALL declare port: req_ack  input  1  core consumed request.
REQ-011 SHALL declare ports: err_valid output 1; err_code output 8 -- ERROR response to be returned to driver.
REQ-012 SHALL declare port: err_ack  input  1  driver consumed error.
REQ-013 SHALL declare port: busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CHECK, REQ_OUT, ERR_OUT.
REQ-015 SHALL assert msg_ready only in IDLE; msg_valid&&msg_ready captures msg_in/msg_src into registers and moves to CHECK.
REQ-016 SHALL ignore msg_valid in all non-IDLE states (no capture, no error).
REQ-017 SHALL in CHECK (exactly one cycle) apply checks in priority order: version!=8'h01 -> err 8'h02; type not in {8'h81 GET_DIGESTS, 8'h82 GET_CERTIFICATE, 8'h83 CHALLENGE} -> err 8'h01; type 8'h82 or 8'h83 with param1>=8 or slot_mask[param1[2:0]]==0 -> err 8'h01; type 8'h82 with length==0 or length>16'h0100 -> err 8'h01.
REQ-018 SHALL compute offset+length as 17-bit sum for GET_CERTIFICATE; carry out (sum>17'h0FFFF) -> err 8'h01.
REQ-019 SHALL on pass enter REQ_OUT with req_valid=1 and fields registered; req_offset/req_length zero for types 8'h81/8'h83; req_slot zero for 8'h81.
REQ-020 SHALL on fail enter ERR_OUT with err_valid=1, err_code per REQ-017/018.
REQ-021 SHALL give latency: acceptance edge N -> req_valid or err_valid high after edge N+2.
REQ-022 SHALL hold req_* / err_* stable while valid; clear valid and return to IDLE on the edge where matching ack is sampled high.
REQ-023 SHALL ignore req_ack outside REQ_OUT and err_ack outside ERR_OUT.
REQ-024 SHALL never assert req_valid and err_valid together.
REQ-025 SHALL allow back-to-back: msg_ready high the cycle after ack, next message accepted then.

Reset
REQ-026 SHALL on reset low, immediately (asynchronously) force IDLE, msg_ready=1, busy=0, req_valid=0, err_valid=0, all data outputs 0, watchdog 0.
REQ-027 SHALL abandon any in-flight message on reset mid-operation; no output pulse after release.

Configuration
REQ-028 SHALL with AUTH_RX_TIMEOUT_EN defined, count cycles in REQ_OUT/ERR_OUT; counter clears on state entry; reaching TIMEOUT_CYCLES without ack drops req_valid/err_valid and returns to IDLE next edge.
REQ-029 SHALL with AUTH_RX_TIMEOUT_EN undefined, contain no watchdog logic; REQ_OUT/ERR_OUT wait indefinitely for ack.

Verification
REQ-030 SHALL test: msg {01,82,00,00,0000,0095}, slot_mask=8'h01, req_ack 3 cycles later -> req_valid at N+2, type 82, slot 0, offset 0000, length 0095, cleared after ack.
REQ-031 SHALL test: msg {01,82,00,00,0000,0103} -> err_valid at N+2, err_code 01, no req_valid.
REQ-032 SHALL test: version 02 -> err_code 02; type 84 -> err_code 01; GET_CERTIFICATE param1=03 with slot_mask=8'h01 -> err_code 01; offset FFF0 length 0020 -> err_code 01.
REQ-033 SHALL test: second msg_valid while REQ_OUT -> msg_ready=0, not captured; accepted cycle after req_ack.
REQ-034 SHALL test: reset low while REQ_OUT -> req_valid=0, busy=0, msg_ready=1 without clock edge.
REQ-035 SHALL test with AUTH_RX_TIMEOUT_EN, TIMEOUT_CYCLES=16, no req_ack -> req_valid drops after 16 cycles, IDLE; without macro, held indefinitely.

Source files
------------

// File: rtl/auth_req_rx.sv
// Authentication request receiver: captures a message, validates it in one CHECK cycle,
// then presents a decoded request or an error code. Optional ack watchdog: AUTH_RX_TIMEOUT_EN.
`timescale 1ns/1ps
`ifndef MSG_LEN
`define MSG_LEN 64
`endif

module auth_req_rx #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                msg_valid,
    input  logic [`MSG_LEN-1:0] msg_in,
    input  logic                msg_src,
    input  logic [7:0]          slot_mask,
    output logic                msg_ready,
    output logic                req_valid,
    output logic [7:0]          req_type,
    output logic [2:0]          req_slot,
    output logic [15:0]         req_offset,
    output logic [15:0]         req_length,
    output logic                req_src,
    input  logic                req_ack,
    output logic                err_valid,
    output logic [7:0]          err_code,
    input  logic                err_ack,
    output logic                busy
);
    localparam int ML = `MSG_LEN;

    typedef enum logic [1:0] {IDLE, CHECK, REQ_OUT, ERR_OUT} state_t;

    state_t      state_reg, state_next;
    logic        pend_reg;
    logic [7:0]  version_reg, type_reg, param1_reg;
    logic [15:0] offset_reg, length_reg;
    logic        src_reg;

    logic        req_valid_reg, err_valid_reg, req_src_reg;
    logic [7:0]  req_type_reg, err_code_reg;
    logic [2:0]  req_slot_reg;
    logic [15:0] req_offset_reg, req_length_reg;

    logic        accept;
    logic        check_fail;
    logic [7:0]  check_code;
    logic [16:0] end_sum;
    logic        slot_ok;
    logic        unused_param2;

    assign unused_param2 = ^msg_in[ML-25 -: 8];

    assign msg_ready = (state_reg == IDLE) && !pend_reg;
    assign accept    = msg_valid && msg_ready;
    // The capture cycle counts as busy: the message is already owned by the block.
    assign busy      = (state_reg != IDLE) || pend_reg;

`ifdef AUTH_RX_TIMEOUT_EN
    logic [15:0] wd_reg;
    logic        wd_expired;

    assign wd_expired = (wd_reg == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_reg <= '0;
        end else if ((state_reg == REQ_OUT || state_reg == ERR_OUT) && state_next == state_reg) begin
            wd_reg <= wd_reg + 16'd1;
        end else begin
            wd_reg <= '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_reg    <= 1'b0;
            version_reg <= '0;
            type_reg    <= '0;
            param1_reg  <= '0;
            offset_reg  <= '0;
            length_reg  <= '0;
            src_reg     <= 1'b0;
        end else begin
            pend_reg <= accept;
            if (accept) begin
                version_reg <= msg_in[ML-1  -: 8];
                type_reg    <= msg_in[ML-9  -: 8];
                param1_reg  <= msg_in[ML-17 -: 8];
                offset_reg  <= msg_in[ML-33 -: 16];
                length_reg  <= msg_in[ML-49 -: 16];
                src_reg     <= msg_src;
            end
        end
    end

    // Validation checks, highest priority first.
    always_comb begin
        check_fail = 1'b0;
        check_code = 8'h00;
        end_sum    = {1'b0, offset_reg} + {1'b0, length_reg};
        slot_ok    = (param1_reg < 8'd8) && slot_mask[param1_reg[2:0]];
        if (version_reg != 8'h01) begin
            check_fail = 1'b1;
            check_code = 8'h02;
        end else if (type_reg != 8'h81 && type_reg != 8'h82 && type_reg != 8'h83) begin
            check_fail = 1'b1;
            check_code = 8'h01;
        end else if (type_reg != 8'h81 && !slot_ok) begin
            check_fail = 1'b1;
            check_code = 8'h01;
        end else if (type_reg == 8'h82 && (length_reg == 16'h0000 || length_reg > 16'h0100)) begin
            check_fail = 1'b1;
            check_code = 8'h01;
        end else if (type_reg == 8'h82 && end_sum[16]) begin
            check_fail = 1'b1;
            check_code = 8'h01;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pend_reg) state_next = CHECK;
            CHECK:   state_next = check_fail ? ERR_OUT : REQ_OUT;
            REQ_OUT: begin
                if (req_ack) state_next = IDLE;
`ifdef AUTH_RX_TIMEOUT_EN
                else if (wd_expired) state_next = IDLE;
`endif
            end
            ERR_OUT: begin
                if (err_ack) state_next = IDLE;
`ifdef AUTH_RX_TIMEOUT_EN
                else if (wd_expired) state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_valid_reg  <= 1'b0;
            err_valid_reg  <= 1'b0;
            req_type_reg   <= '0;
            req_slot_reg   <= '0;
            req_offset_reg <= '0;
            req_length_reg <= '0;
            req_src_reg    <= 1'b0;
            err_code_reg   <= '0;
        end else begin
            req_valid_reg <= (state_next == REQ_OUT);
            err_valid_reg <= (state_next == ERR_OUT);
            if (state_reg == CHECK) begin
                if (check_fail) begin
                    err_code_reg <= check_code;
                end else begin
                    req_type_reg   <= type_reg;
                    req_slot_reg   <= (type_reg == 8'h81) ? 3'd0 : param1_reg[2:0];
                    req_offset_reg <= (type_reg == 8'h82) ? offset_reg : 16'h0000;
                    req_length_reg <= (type_reg == 8'h82) ? length_reg : 16'h0000;
                    req_src_reg    <= src_reg;
                end
            end else if (state_next == IDLE) begin
                req_type_reg   <= '0;
                req_slot_reg   <= '0;
                req_offset_reg <= '0;
                req_length_reg <= '0;
                req_src_reg    <= 1'b0;
                err_code_reg   <= '0;
            end
        end
    end

    assign req_valid  = req_valid_reg;
    assign req_type   = req_type_reg;
    assign req_slot   = req_slot_reg;
    assign req_offset = req_offset_reg;
    assign req_length = req_length_reg;
    assign req_src    = req_src_reg;
    assign err_valid  = err_valid_reg;
    assign err_code   = err_code_reg;

endmodule

// File: tb/tb_auth_req_rx.sv
// Scoreboard bench for auth_req_rx: a reference model predicts each message's outcome
// when it is driven; results are popped and compared when the DUT presents them.
`timescale 1ns/1ps
`ifndef MSG_LEN
`define MSG_LEN 64
`endif

module tb_auth_req_rx;
    localparam logic [15:0] TO = 16'd16;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                msg_valid = 1'b0;
    logic [`MSG_LEN-1:0] msg_in = '0;
    logic                msg_src = 1'b0;
    logic [7:0]          slot_mask = 8'h00;
    logic                msg_ready;
    logic                req_valid;
    logic [7:0]          req_type;
    logic [2:0]          req_slot;
    logic [15:0]         req_offset;
    logic [15:0]         req_length;
    logic                req_src;
    logic                req_ack = 1'b0;
    logic                err_valid;
    logic [7:0]          err_code;
    logic                err_ack = 1'b0;
    logic                busy;

    auth_req_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .msg_valid(msg_valid), .msg_in(msg_in), .msg_src(msg_src), .slot_mask(slot_mask),
        .msg_ready(msg_ready),
        .req_valid(req_valid), .req_type(req_type), .req_slot(req_slot),
        .req_offset(req_offset), .req_length(req_length), .req_src(req_src),
        .req_ack(req_ack),
        .err_valid(err_valid), .err_code(err_code), .err_ack(err_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [7:0]  code;
        logic [7:0]  typ;
        logic [2:0]  slot;
        logic [15:0] off;
        logic [15:0] len;
        logic        src;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] mk(input logic [7:0] v, input logic [7:0] t, input logic [7:0] p1,
                                       input logic [7:0] p2, input logic [15:0] o, input logic [15:0] l);
        return {v, t, p1, p2, o, l};
    endfunction

    function automatic exp_t model(input logic [63:0] m, input logic s, input logic [7:0] mask);
        exp_t e;
        int   v, t, p1, o, l;
        v = int'(m[63:56]); t = int'(m[55:48]); p1 = int'(m[47:40]);
        o = int'(m[31:16]); l = int'(m[15:0]);
        e = '0;
        if (v != 1) begin
            e.is_err = 1'b1; e.code = 8'h02;
        end else if (t < 'h81 || t > 'h83) begin
            e.is_err = 1'b1; e.code = 8'h01;
        end else if (t != 'h81 && (p1 >= 8 || mask[p1 % 8] == 1'b0)) begin
            e.is_err = 1'b1; e.code = 8'h01;
        end else if (t == 'h82 && (l == 0 || l > 256)) begin
            e.is_err = 1'b1; e.code = 8'h01;
        end else if (t == 'h82 && o + l > 65535) begin
            e.is_err = 1'b1; e.code = 8'h01;
        end else begin
            e.typ  = 8'(t);
            e.slot = (t == 'h81) ? 3'd0 : 3'(p1 % 8);
            e.off  = (t == 'h82) ? 16'(o) : 16'h0;
            e.len  = (t == 'h82) ? 16'(l) : 16'h0;
            e.src  = s;
        end
        return e;
    endfunction

    // Present a message, wait for acceptance, and record the predicted outcome.
    task automatic send(input logic [63:0] m, input logic s, input logic [7:0] mask);
        int w = 0;
        slot_mask = mask;
        msg_in    = m;
        msg_src   = s;
        msg_valid = 1'b1;
        while (!msg_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 20) check_eq("ready_timeout", 32'(msg_ready), 32'd1);
        @(posedge clk); #1;
        msg_valid = 1'b0;
        sb_q.push_back(model(m, s, mask));
        check_eq("busy_after_accept", 32'(busy), 32'd1);
        check_eq("ready_after_accept", 32'(msg_ready), 32'd0);
    endtask

    task automatic compare_out(input string name, input exp_t e);
        check_eq({name, "_valid"}, 32'({req_valid, err_valid}), e.is_err ? 32'd1 : 32'd2);
        if (e.is_err) begin
            check_eq({name, "_err_code"}, 32'(err_code), 32'(e.code));
        end else begin
            check_eq({name, "_type"}, 32'(req_type), 32'(e.typ));
            check_eq({name, "_slot"}, 32'(req_slot), 32'(e.slot));
            check_eq({name, "_offset"}, 32'(req_offset), 32'(e.off));
            check_eq({name, "_length"}, 32'(req_length), 32'(e.len));
            check_eq({name, "_src"}, 32'(req_src), 32'(e.src));
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!(req_valid || err_valid) && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    // Wait for the result, hold it for 'hold' cycles, then acknowledge. Optionally pulse the
    // wrong ack first, and optionally keep a second message pending throughout (bg).
    task automatic collect(input string name, input int hold, input bit wrong_ack,
                           input bit bg, input logic [63:0] m2);
        int   lat;
        exp_t e;
        wait_valid(lat);
        check_eq({name, "_latency"}, 32'(lat), 32'd2);
        if (sb_q.size() == 0) begin
            check_eq({name, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        compare_out(name, e);
        if (bg) begin
            msg_in = m2; msg_src = 1'b1; msg_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            if (wrong_ack && i == 0) begin
                if (e.is_err) req_ack = 1'b1; else err_ack = 1'b1;
            end
            @(posedge clk); #1;
            req_ack = 1'b0; err_ack = 1'b0;
            compare_out({name, "_hold"}, e);
            if (bg) check_eq({name, "_ready_blocked"}, 32'(msg_ready), 32'd0);
        end
        if (e.is_err) err_ack = 1'b1; else req_ack = 1'b1;
        @(posedge clk); #1;
        req_ack = 1'b0; err_ack = 1'b0;
        check_eq({name, "_cleared"}, 32'({req_valid, err_valid}), 32'd0);
        check_eq({name, "_ready_after_ack"}, 32'(msg_ready), 32'd1);
        $display("txn %s: err=%0d code=%h type=%h slot=%0d off=%h len=%h src=%0d lat=%0d",
                 name, e.is_err, e.code, e.typ, e.slot, e.off, e.len, e.src, lat);
        if (bg) begin
            @(posedge clk); #1;
            msg_valid = 1'b0;
            sb_q.push_back(model(m2, 1'b1, slot_mask));
            check_eq({name, "_bg_accepted"}, 32'(busy), 32'd1);
        end else begin
            check_eq({name, "_idle_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int          lat;
        int          hi;
        logic        saw;
        logic [63:0] rm;
        logic [7:0]  rtypes [4];

        rtypes[0] = 8'h81; rtypes[1] = 8'h82; rtypes[2] = 8'h83; rtypes[3] = 8'h84;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(msg_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valids", 32'({req_valid, err_valid}), 32'd0);
        check_eq("rst_data", 32'({req_type, req_slot, req_src, err_code}), 32'd0);
        check_eq("rst_data2", {req_offset, req_length}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        send(mk(8'h01, 8'h82, 8'h00, 8'h00, 16'h0000, 16'h0095), 1'b0, 8'h01);
        collect("cert_ok", 3, 1'b1, 1'b0, '0);
        send(mk(8'h01, 8'h82, 8'h00, 8'h00, 16'h0000, 16'h0103), 1'b0, 8'h01);
        collect("len_too_big", 1, 1'b1, 1'b0, '0);
        send(mk(8'h02, 8'h82, 8'h00, 8'h00, 16'h0000, 16'h0010), 1'b0, 8'h01);
        collect("bad_version", 0, 1'b0, 1'b0, '0);
        send(mk(8'h01, 8'h84, 8'h00, 8'h00, 16'h0000, 16'h0010), 1'b0, 8'h01);
        collect("bad_type", 0, 1'b0, 1'b0, '0);
        send(mk(8'h01, 8'h82, 8'h03, 8'h00, 16'h0000, 16'h0010), 1'b0, 8'h01);
        collect("unprov_slot", 0, 1'b0, 1'b0, '0);
        send(mk(8'h01, 8'h82, 8'h00, 8'h00, 16'hFFF0, 16'h0020), 1'b0, 8'h01);
        collect("offset_wrap", 0, 1'b0, 1'b0, '0);
        send(mk(8'h01, 8'h82, 8'h00, 8'h00, 16'hFEFF, 16'h0100), 1'b1, 8'h01);
        collect("end_ffff_ok", 0, 1'b0, 1'b0, '0);
        send(mk(8'h01, 8'h82, 8'h00, 8'h00, 16'hFF00, 16'h0100), 1'b0, 8'h01);
        collect("end_10000", 0, 1'b0, 1'b0, '0);
        send(mk(8'h01, 8'h82, 8'h00, 8'h00, 16'h0000, 16'h0000), 1'b0, 8'h01);
        collect("len_zero", 0, 1'b0, 1'b0, '0);
        send(mk(8'h01, 8'h81, 8'h05, 8'h11, 16'h1234, 16'h0040), 1'b1, 8'h00);
        collect("digests", 1, 1'b0, 1'b0, '0);
        send(mk(8'h01, 8'h83, 8'h05, 8'h22, 16'h1234, 16'h0040), 1'b0, 8'h20);
        collect("challenge", 1, 1'b0, 1'b0, '0);
        send(mk(8'h01, 8'h83, 8'h08, 8'h00, 16'h0000, 16'h0000), 1'b0, 8'hFF);
        collect("param1_8", 0, 1'b0, 1'b0, '0);
        send(mk(8'h02, 8'h84, 8'h09, 8'h00, 16'h0000, 16'h0000), 1'b0, 8'h00);
        collect("prio_version", 0, 1'b0, 1'b0, '0);

        // Second message held during REQ_OUT, accepted the cycle after req_ack.
        send(mk(8'h01, 8'h82, 8'h01, 8'h00, 16'h0010, 16'h0080), 1'b0, 8'h03);
        collect("b2b_first", 3, 1'b0, 1'b1, mk(8'h01, 8'h83, 8'h00, 8'h00, 16'h0000, 16'h0000));
        collect("b2b_second", 0, 1'b0, 1'b0, '0);

        for (int i = 0; i < 16; i++) begin
            rm = mk(($urandom_range(0, 7) == 0) ? 8'h02 : 8'h01,
                    rtypes[$urandom_range(0, 3)],
                    8'($urandom_range(0, 9)),
                    8'($urandom_range(0, 255)),
                    ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hFF00, 16'hFFFF))
                                                : 16'($urandom_range(0, 16'h0400)),
                    16'($urandom_range(0, 16'h0110)));
            send(rm, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            collect("rnd", $urandom_range(0, 2), 1'b0, 1'b0, '0);
        end

        // Asynchronous reset while REQ_OUT.
        send(mk(8'h01, 8'h81, 8'h00, 8'h00, 16'h0000, 16'h0000), 1'b0, 8'h01);
        wait_valid(lat);
        check_eq("rst_mid_pre_valid", 32'(req_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("rst_mid_req_valid", 32'(req_valid), 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_ready", 32'(msg_ready), 32'd1);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            saw = saw | req_valid | err_valid;
        end
        check_eq("rst_mid_no_pulse", 32'(saw), 32'd0);

        // Reset during CHECK: the message must be abandoned.
        send(mk(8'h01, 8'h82, 8'h00, 8'h00, 16'h0000, 16'h0010), 1'b0, 8'h01);
        @(posedge clk); #1;
        reset = 1'b0;
        #1 reset = 1'b1;
        sb_q.delete();
        saw = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            saw = saw | req_valid | err_valid;
        end
        check_eq("rst_check_no_pulse", 32'(saw), 32'd0);
        check_eq("rst_check_ready", 32'(msg_ready), 32'd1);

        // Watchdog: with the feature the request drops after TO cycles, otherwise it holds.
        send(mk(8'h01, 8'h83, 8'h00, 8'h00, 16'h0000, 16'h0000), 1'b0, 8'h01);
        wait_valid(lat);
        check_eq("wd_latency", 32'(lat), 32'd2);
        void'(sb_q.pop_front());
        hi = 0;
        while (req_valid && hi < 40) begin
            hi++;
            @(posedge clk); #1;
        end
`ifdef AUTH_RX_TIMEOUT_EN
        check_eq("wd_high_cycles", 32'(hi), 32'(TO));
        check_eq("wd_idle_busy", 32'(busy), 32'd0);
        check_eq("wd_idle_ready", 32'(msg_ready), 32'd1);
`else
        check_eq("wd_held", 32'(hi), 32'd40);
        check_eq("wd_still_busy", 32'(busy), 32'd1);
        req_ack = 1'b1;
        @(posedge clk); #1;
        req_ack = 1'b0;
        check_eq("wd_ack_clear", 32'(req_valid), 32'd0);
`endif
        $display("txn watchdog: high_cycles=%0d", hi);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end
endmodule
